// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch and load/store.
// Data has fixed priority; a starvation counter forces a fetch grant after MAX_STARVE data wins.
module mem_port_arbiter #(
    parameter int unsigned AW          = 30,
    parameter int unsigned DW          = 32,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned MAX_STARVE  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic [DW-1:0]     if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    input  logic [DW/8-1:0]   d_be,
    output logic [DW-1:0]     d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_be,
    input  logic [DW-1:0]     mem_rdata
);

    localparam int unsigned   CW         = 4;
    localparam logic [CW-1:0] WAIT_LOAD  = CW'(WAIT_STATES);
    localparam logic [CW-1:0] STARVE_MAX = CW'(MAX_STARVE);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] starve_cnt;
    logic          owner_d;
    logic          grant_d;
    logic          grant_if;

    // Arbitration decode, only acted upon in IDLE
    always_comb begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (d_req && !(if_req && (starve_cnt == STARVE_MAX))) begin
            grant_d = 1'b1;
        end else if (if_req) begin
            grant_if = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            owner_d    <= 1'b0;
            if_rdata   <= '0;
            if_ack     <= 1'b0;
            d_rdata    <= '0;
            d_ack      <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= ACCESS;
                        owner_d   <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                        wait_cnt  <= WAIT_LOAD;
                        // Only data wins that hold off a pending fetch count toward starvation
                        if (!if_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != STARVE_MAX) begin
                            starve_cnt <= starve_cnt + CW'(1);
                        end
                    end else if (grant_if) begin
                        state      <= ACCESS;
                        owner_d    <= 1'b0;
                        mem_en     <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_be     <= '1;
                        wait_cnt   <= WAIT_LOAD;
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end else begin
                        state  <= RESP;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (owner_d) begin
                            d_ack <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (WAIT_STATES=1 and 0) checked every cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int MS  = 4;
    localparam int NW  = 64;
    localparam int WS0 = 1;
    localparam int WS1 = 0;

    logic clk = 1'b0;
    logic reset;

    logic            if_req    [2];
    logic [AW-1:0]   if_addr   [2];
    logic [DW-1:0]   if_rdata  [2];
    logic            if_ack    [2];
    logic            d_req     [2];
    logic            d_we      [2];
    logic [AW-1:0]   d_addr    [2];
    logic [DW-1:0]   d_wdata   [2];
    logic [BW-1:0]   d_be      [2];
    logic [DW-1:0]   d_rdata   [2];
    logic            d_ack     [2];
    logic            mem_en    [2];
    logic            mem_we    [2];
    logic [AW-1:0]   mem_addr  [2];
    logic [DW-1:0]   mem_wdata [2];
    logic [BW-1:0]   mem_be    [2];
    logic [DW-1:0]   mem_rdata [2];

    // Bench-side RAM driven by the DUT, and the model's own view of memory contents
    logic [DW-1:0] mem_arr [2][NW];
    logic [DW-1:0] ref_mem [2][NW];

    // Expected outputs maintained by the model
    int            m_left   [2];
    int            m_starve [2];
    logic          m_own_d  [2];
    logic          m_isw    [2];
    logic          e_en     [2];
    logic          e_we     [2];
    logic [AW-1:0] e_addr   [2];
    logic [DW-1:0] e_wdata  [2];
    logic [BW-1:0] e_be     [2];
    logic [DW-1:0] e_ifr    [2];
    logic [DW-1:0] e_dr     [2];
    logic          e_ifa    [2];
    logic          e_da     [2];

    int   total;
    int   bad;
    int   cyc;
    int   p_if;
    int   p_d;
    logic armed;
    logic auto_mode;
    int   nacks [2];
    int   kind  [2][32];
    int   tstmp [2][32];

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(WS0), .MAX_STARVE(MS)) u_ws1 (
        .clk(clk), .reset(reset),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ack(if_ack[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_be(d_be[0]),
        .d_rdata(d_rdata[0]), .d_ack(d_ack[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_be(mem_be[0]), .mem_rdata(mem_rdata[0])
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(WS1), .MAX_STARVE(MS)) u_ws0 (
        .clk(clk), .reset(reset),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ack(if_ack[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_be(d_be[1]),
        .d_rdata(d_rdata[1]), .d_ack(d_ack[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_be(mem_be[1]), .mem_rdata(mem_rdata[1])
    );

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", name, k, $time, act, exp);
        end
    endtask

    // Transaction view: a grant occupies WS+1 access cycles and one response cycle
    task automatic model_step(input int k);
        int   ws;
        logic gd;
        logic gf;
        ws = (k == 0) ? WS0 : WS1;
        if (reset) begin
            m_left[k] = 0; m_starve[k] = 0; m_own_d[k] = 1'b0; m_isw[k] = 1'b0;
            e_en[k] = 1'b0; e_we[k] = 1'b0; e_addr[k] = '0; e_wdata[k] = '0; e_be[k] = '0;
            e_ifr[k] = '0; e_dr[k] = '0; e_ifa[k] = 1'b0; e_da[k] = 1'b0;
        end else if (m_left[k] == 0) begin
            gd = d_req[k] && !(if_req[k] && (m_starve[k] == MS));
            gf = if_req[k] && !gd;
            if (gd) begin
                if (if_req[k]) m_starve[k] = (m_starve[k] < MS) ? m_starve[k] + 1 : MS;
                else           m_starve[k] = 0;
                m_own_d[k] = 1'b1; m_isw[k] = d_we[k];
                e_en[k] = 1'b1; e_we[k] = d_we[k]; e_addr[k] = d_addr[k];
                e_wdata[k] = d_wdata[k]; e_be[k] = d_be[k];
                if (d_we[k]) begin
                    for (int b = 0; b < BW; b++)
                        if (d_be[k][b]) ref_mem[k][d_addr[k][5:0]][8*b +: 8] = d_wdata[k][8*b +: 8];
                end
                m_left[k] = ws + 2;
            end else if (gf) begin
                m_starve[k] = 0;
                m_own_d[k] = 1'b0; m_isw[k] = 1'b0;
                e_en[k] = 1'b1; e_we[k] = 1'b0; e_addr[k] = if_addr[k]; e_be[k] = '1;
                m_left[k] = ws + 2;
            end else begin
                m_starve[k] = 0;
            end
        end else begin
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 1) begin
                e_en[k] = 1'b0; e_we[k] = 1'b0;
                if (m_own_d[k]) begin
                    e_da[k] = 1'b1;
                    if (!m_isw[k]) e_dr[k] = ref_mem[k][e_addr[k][5:0]];
                end else begin
                    e_ifa[k] = 1'b1;
                    e_ifr[k] = ref_mem[k][e_addr[k][5:0]];
                end
            end else if (m_left[k] == 0) begin
                e_ifa[k] = 1'b0; e_da[k] = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // Every-cycle comparison of all outputs against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (armed) begin
                for (int k = 0; k < 2; k++) begin
                    chk("mem_en", k, 64'(mem_en[k]), 64'(e_en[k]));
                    chk("mem_we", k, 64'(mem_we[k]), 64'(e_we[k]));
                    chk("mem_addr", k, 64'(mem_addr[k]), 64'(e_addr[k]));
                    chk("mem_wdata", k, 64'(mem_wdata[k]), 64'(e_wdata[k]));
                    chk("mem_be", k, 64'(mem_be[k]), 64'(e_be[k]));
                    chk("if_ack", k, 64'(if_ack[k]), 64'(e_ifa[k]));
                    chk("d_ack", k, 64'(d_ack[k]), 64'(e_da[k]));
                    chk("if_rdata", k, 64'(if_rdata[k]), 64'(e_ifr[k]));
                    chk("d_rdata", k, 64'(d_rdata[k]), 64'(e_dr[k]));
                    chk("ack_overlap", k, 64'(if_ack[k] & d_ack[k]), 64'd0);
                    chk("en_with_ack", k, 64'(mem_en[k] & (if_ack[k] | d_ack[k])), 64'd0);
                end
            end
        end
    end

    task automatic drive_reqs(input int k);
        if (if_req[k] && if_ack[k]) if_req[k] = 1'b0;
        if (d_req[k] && d_ack[k])   d_req[k]  = 1'b0;
        if (!if_req[k]) begin
            if_addr[k] = AW'($urandom_range(NW - 1));
            if ($urandom_range(99) < p_if) if_req[k] = 1'b1;
        end
        if (!d_req[k]) begin
            d_addr[k]  = AW'($urandom_range(NW - 1));
            d_wdata[k] = DW'($urandom);
            d_be[k]    = BW'($urandom);
            d_we[k]    = 1'($urandom_range(1));
            if ($urandom_range(99) < p_d) d_req[k] = 1'b1;
        end
    endtask

    // Advance to the next falling edge; service the bench RAM and requesters there
    task automatic step();
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (mem_en[k] && mem_we[k]) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be[k][b]) mem_arr[k][mem_addr[k][5:0]][8*b +: 8] = mem_wdata[k][8*b +: 8];
            end
            mem_rdata[k] = mem_en[k] ? mem_arr[k][mem_addr[k][5:0]] : DW'($urandom);
            if (auto_mode) drive_reqs(k);
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; p_if = 0; p_d = 0;
        armed = 1'b0; auto_mode = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
            d_addr[k] = '0; d_wdata[k] = '0; d_be[k] = '0; mem_rdata[k] = '0; nacks[k] = 0;
            for (int i = 0; i < NW; i++) begin
                mem_arr[k][i] = DW'($urandom);
                ref_mem[k][i] = mem_arr[k][i];
            end
            mem_arr[k][16] = 32'hDEADBEEF; ref_mem[k][16] = 32'hDEADBEEF;
            mem_arr[k][33] = 32'h0BADF00D; ref_mem[k][33] = 32'h0BADF00D;
        end
        repeat (3) step();
        reset = 1'b0;
        armed = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_mem_en", k, 64'(mem_en[k]), 64'd0);
            chk("rst_mem_addr", k, 64'(mem_addr[k]), 64'd0);
            chk("rst_if_rdata", k, 64'(if_rdata[k]), 64'd0);
            chk("rst_d_rdata", k, 64'(d_rdata[k]), 64'd0);
        end

        // Lone fetch on the one-wait-state instance
        if_req[0] = 1'b1; if_addr[0] = AW'(16);
        step();
        chk("fetch_en1", 0, 64'(mem_en[0]), 64'd1);
        chk("fetch_we", 0, 64'(mem_we[0]), 64'd0);
        chk("fetch_be", 0, 64'(mem_be[0]), 64'hF);
        chk("fetch_addr", 0, 64'(mem_addr[0]), 64'h10);
        step();
        chk("fetch_en2", 0, 64'(mem_en[0]), 64'd1);
        chk("fetch_ack_early", 0, 64'(if_ack[0]), 64'd0);
        step();
        chk("fetch_en_off", 0, 64'(mem_en[0]), 64'd0);
        chk("fetch_ack", 0, 64'(if_ack[0]), 64'd1);
        chk("fetch_rdata", 0, 64'(if_rdata[0]), 64'hDEADBEEF);
        if_req[0] = 1'b0;
        step();
        chk("fetch_ack_pulse", 0, 64'(if_ack[0]), 64'd0);
        chk("fetch_rdata_hold", 0, 64'(if_rdata[0]), 64'hDEADBEEF);

        // Data write with partial byte enables
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = AW'(32); d_wdata[0] = 32'h12345678; d_be[0] = 4'h3;
        step();
        chk("wr_en", 0, 64'(mem_en[0]), 64'd1);
        chk("wr_we1", 0, 64'(mem_we[0]), 64'd1);
        chk("wr_addr", 0, 64'(mem_addr[0]), 64'h20);
        chk("wr_wdata", 0, 64'(mem_wdata[0]), 64'h12345678);
        chk("wr_be", 0, 64'(mem_be[0]), 64'h3);
        step();
        chk("wr_we2", 0, 64'(mem_we[0]), 64'd1);
        step();
        chk("wr_ack", 0, 64'(d_ack[0]), 64'd1);
        chk("wr_we_off", 0, 64'(mem_we[0]), 64'd0);
        chk("wr_rdata_kept", 0, 64'(d_rdata[0]), 64'd0);
        chk("wr_mem_low", 0, 64'(mem_arr[0][32][15:0]), 64'h5678);
        d_req[0] = 1'b0; d_we[0] = 1'b0;
        step();
        chk("wr_ack_pulse", 0, 64'(d_ack[0]), 64'd0);

        // Simultaneous requests: data first, fetch in the following IDLE
        if_req[0] = 1'b1; if_addr[0] = AW'(16);
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = AW'(33); d_be[0] = 4'hF;
        step();
        chk("both_first_addr", 0, 64'(mem_addr[0]), 64'h21);
        step();
        step();
        chk("both_d_ack", 0, 64'(d_ack[0]), 64'd1);
        chk("both_if_ack_low", 0, 64'(if_ack[0]), 64'd0);
        chk("both_d_rdata", 0, 64'(d_rdata[0]), 64'h0BADF00D);
        d_req[0] = 1'b0;
        step();
        chk("both_idle", 0, 64'(mem_en[0]), 64'd0);
        step();
        chk("both_fetch_en", 0, 64'(mem_en[0]), 64'd1);
        chk("both_fetch_addr", 0, 64'(mem_addr[0]), 64'h10);
        step();
        step();
        chk("both_if_ack", 0, 64'(if_ack[0]), 64'd1);
        chk("both_d_ack_low", 0, 64'(d_ack[0]), 64'd0);
        if_req[0] = 1'b0;
        step();

        // Reset in the middle of a data read
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = AW'(33);
        step();
        chk("rm_access", 0, 64'(mem_en[0]), 64'd1);
        reset = 1'b1;
        #1;
        chk("rm_en", 0, 64'(mem_en[0]), 64'd0);
        chk("rm_addr", 0, 64'(mem_addr[0]), 64'd0);
        chk("rm_d_rdata", 0, 64'(d_rdata[0]), 64'd0);
        chk("rm_if_rdata", 0, 64'(if_rdata[0]), 64'd0);
        step();
        chk("rm_no_ack", 0, 64'(d_ack[0]), 64'd0);
        reset = 1'b0;
        step();
        chk("rm_retry_en", 0, 64'(mem_en[0]), 64'd1);
        chk("rm_retry_addr", 0, 64'(mem_addr[0]), 64'h21);
        step();
        chk("rm_retry_wait", 0, 64'(d_ack[0]), 64'd0);
        step();
        chk("rm_retry_ack", 0, 64'(d_ack[0]), 64'd1);
        chk("rm_retry_rdata", 0, 64'(d_rdata[0]), 64'h0BADF00D);
        d_req[0] = 1'b0;
        step();
        step();

        // Starvation: both requesters always pending on both instances
        p_if = 100; p_d = 100;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b1; if_addr[k] = AW'($urandom_range(NW - 1));
            d_req[k] = 1'b1; d_we[k] = 1'($urandom_range(1)); d_addr[k] = AW'($urandom_range(NW - 1));
            d_wdata[k] = DW'($urandom); d_be[k] = BW'($urandom);
        end
        auto_mode = 1'b1;
        for (int c = 0; c < 60; c++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                if ((if_ack[k] || d_ack[k]) && nacks[k] < 32) begin
                    kind[k][nacks[k]]  = if_ack[k] ? 1 : 0;
                    tstmp[k][nacks[k]] = cyc;
                    nacks[k]++;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk("starve_ack_count", k, 64'(nacks[k] >= 10), 64'd1);
            for (int i = 0; i < 10 && i < nacks[k]; i++)
                chk("starve_order", k, 64'(kind[k][i]), 64'((i % 5 == 4) ? 1 : 0));
            for (int i = 0; i < 9 && i + 1 < nacks[k]; i++)
                chk("ack_spacing", k, 64'(tstmp[k][i+1] - tstmp[k][i]), 64'((k == 0) ? 4 : 3));
        end

        // Random traffic with varying request densities
        for (int phase = 0; phase < 6; phase++) begin
            p_if = $urandom_range(100);
            p_d  = $urandom_range(100);
            repeat (500) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between the MIPS instruction-fetch unit and the load/store unit.
- Arbitrates with fixed priority to data, plus a starvation guard for fetch.
- Sequences each access through a fixed number of wait states and returns read data with a one-cycle ack to the winner.
- Sits between the core's fetch/MEM stages and the shared block RAM; stalling is the core's responsibility, driven by `ack`.

Parameters:
- AW, 30: word-address width.
- DW, 32: data width; must be a multiple of 8.
- WAIT_STATES, 1: extra memory cycles per access beyond the first; range 0..15.
- MAX_STARVE, 4: consecutive data grants allowed while `if_req` is pending before fetch is forced; range 1..15.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until `if_ack`.
- if_addr  in  AW  fetch word address.
- if_rdata  out  DW  fetch read data; valid when `if_ack`=1 and held afterwards.
- if_ack  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held until `d_ack`.
- d_we  in  1  1=write, 0=read.
- d_addr  in  AW  data word address.
- d_wdata  in  DW  write data.
- d_be  in  DW/8  byte enables for writes.
- d_rdata  out  DW  data read result; valid when `d_ack`=1.
- d_ack  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_be  out  DW/8  memory byte enables.
- mem_rdata  in  DW  memory read data, valid in the last ACCESS cycle.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state, including mid-access):
  - state=IDLE.
  - All outputs 0, including `if_rdata` and `d_rdata`.
  - Wait counter and starvation counter = 0.
  - An in-flight access is abandoned with no ack; the requester re-requests.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE, `mem_en`=0.
  - Otherwise grant according to the arbitration rules below.
  - On grant, latch the winner's addr/we/wdata/be onto the `mem_*` outputs, set `mem_en`=1, load wait counter = WAIT_STATES, go to ACCESS.
  - For a fetch grant: `mem_we`=0, `mem_be`=all ones.
- Arbitration, evaluated only in IDLE:
  - `d_req` only: data wins.
  - `if_req` only: fetch wins.
  - Both asserted: data wins unless starve_cnt == MAX_STARVE, in which case fetch wins.
- Starvation counter:
  - Increments on each data grant made while `if_req`=1, saturating at MAX_STARVE.
  - Clears on any fetch grant.
  - Clears on any IDLE cycle with `if_req`=0.
- ACCESS:
  - `mem_*` outputs held stable.
  - Counter>0: decrement and stay.
  - Counter==0: go to RESP, clear `mem_en` and `mem_we` on the same edge.
  - On that edge, a read captures `mem_rdata` into the owner's rdata register; a write leaves `d_rdata` unchanged.
- RESP:
  - Owner's ack=1 for exactly this cycle; then go to IDLE.
  - Requests are ignored in RESP.
- Requester rule: `req` is deasserted on the edge ending the ack cycle unless a new request follows. The arbiter samples `req` again in the IDLE cycle after RESP.
- Timing:
  - ACCESS lasts WAIT_STATES+1 cycles.
  - Latency from `req` sampled in IDLE to ack = WAIT_STATES+2 cycles.
  - Minimum period per access = WAIT_STATES+3 cycles.
- `mem_addr`, `mem_wdata` and `mem_be` retain their last values in IDLE/RESP; only `mem_en`/`mem_we` qualify them.
- Only the owner's ack pulses; the other rdata and ack outputs are unchanged.
- Request inputs changing during ACCESS/RESP have no effect on the current access.
- `mem_en` and `ack` are never high in the same cycle. `if_ack` and `d_ack` are never high in the same cycle.

Test Plan:
- Reset mid-access: assert `reset` during ACCESS with `d_req`=1 → all outputs 0 immediately, state IDLE, no `d_ack`; after release, the access restarts from IDLE.
- Lone fetch: WAIT_STATES=1; `if_req`=1, addr 0x10, `mem_rdata`=0xDEADBEEF → `mem_en` high 2 cycles with `mem_we`=0 and `mem_be`=0xF; `if_ack` 3 cycles after grant with `if_rdata`=0xDEADBEEF.
- Data write: `d_we`=1, addr 0x20, wdata 0x12345678, be 0x3 → `mem_we`=1 with these values for 2 cycles; one `d_ack`; `d_rdata` unchanged.
- Simultaneous requests: both asserted together → data granted first, fetch granted in the next IDLE; the acks never overlap.
- Starvation: MAX_STARVE=4, `if_req` held, `d_req` reasserted after every ack → exactly 4 data grants, then a fetch grant, then data resumes with starve_cnt=0.
- WAIT_STATES=0: back-to-back reads → `mem_en` 1 cycle per access, ack every 3 cycles, `rdata` matches the per-address memory model.
